// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
//   Shared types and constants for the push-button input stage.
//   - btn_state_t : per-channel debounce FSM state
//   - BTN_*       : bit positions of the five board buttons in the packed buses
//   - N_BTN       : number of board buttons
//   - cnt_width() : bit width of a counter that must hold 0 .. max_val-1
// -----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        ARM      = 2'd1,
        PRESSED  = 2'd2,
        DISARM   = 2'd3
    } btn_state_t;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_D = 2;
    localparam int BTN_R = 3;
    localparam int BTN_L = 4;
    localparam int N_BTN = 5;

    // Width of a counter whose largest value is max_val-1 (at least 1 bit).
    function automatic int cnt_width(input int max_val);
        return (max_val <= 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// -----------------------------------------------------------------------------
// button_debounce_ch
//   One push-button channel: 2-flop synchroniser, four-state debounce FSM and
//   registered level / press / release outputs.
//   Optional auto-repeat of btn_press while held, enabled by the macro
//   BUTTON_CONDITIONER_AUTOREPEAT_EN (default build: no repeat logic).
//
// Ports
//   pixel_clk    in   pixel clock
//   rst          in   synchronous reset, active-high
//   btn_in       in   asynchronous button, already normalised to 1 = pressed
//   btn_level    out  debounced level, 1 = pressed
//   btn_press    out  1-cycle pulse on debounced press (plus auto-repeats)
//   btn_release  out  1-cycle pulse on debounced release
// -----------------------------------------------------------------------------
module button_debounce_ch
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 360_000,
    parameter int REPEAT_DELAY    = 18_000_000,
    parameter int REPEAT_PERIOD   = 3_600_000
) (
    input  logic pixel_clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int              DW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]   DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time parameter sanity checks.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("button_debounce_ch: REPEAT_PERIOD must be >= 1");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("button_debounce_ch: REPEAT_DELAY must be >= 1");
    end

    logic [1:0]    sync_q,    sync_d;
    btn_state_t    state_q,   state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          level_q,   level_d;
    logic          press_q,   press_d;
    logic          release_q, release_d;
    logic          rep_fire;
    logic          sync_btn;

    // Synchroniser: bit 0 may go metastable, bit 1 is the settled sample.
    assign sync_d   = {sync_q[0], btn_in};
    assign sync_btn = sync_q[1];

    // Debounce FSM next state. The counter runs only while the synchronised
    // input disagrees with the debounced level; any agreement restarts it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        unique case (state_q)
            RELEASED: begin
                if (sync_btn) begin
                    state_d   = ARM;
                    deb_cnt_d = '0;
                end
            end
            ARM: begin
                if (!sync_btn) begin
                    state_d   = RELEASED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = PRESSED;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync_btn) begin
                    state_d   = DISARM;
                    deb_cnt_d = '0;
                end
            end
            DISARM: begin
                if (sync_btn) begin
                    state_d   = PRESSED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = RELEASED;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = RELEASED;
                deb_cnt_d = '0;
            end
        endcase
    end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam int            REP_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                          : REPEAT_PERIOD;
    localparam int            RW         = cnt_width(REP_MAX);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt_q,   rep_cnt_d;
    logic          rep_first_q, rep_first_d;   // 1 once the initial delay has elapsed

    // rep_cnt only advances on cycles that start and stay in PRESSED, so it
    // is frozen across a DISARM that bounces back, and cleared on a fresh
    // press or on full release.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_fire    = 1'b0;
        if ((state_d == RELEASED) || (state_d == ARM) ||
            ((state_q == ARM) && (state_d == PRESSED))) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
        end else if ((state_q == PRESSED) && (state_d == PRESSED)) begin
            if (rep_cnt_q == (rep_first_q ? PERIOD_LAST : DELAY_LAST)) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Outputs are registered from the next state so level changes on the
    // same edge the FSM commits to a new debounced value.
    always_comb begin
        level_d   = (state_d == PRESSED) || (state_d == DISARM);
        press_d   = (level_d && !level_q) || rep_fire;
        release_d = !level_d && level_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: reset is synchronous and also clears the synchroniser, so a
    // button held through reset is re-debounced as a brand new press.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            sync_q    <= '0;
            state_q   <= RELEASED;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Input stage for game_logic: synchronises, debounces and edge-detects the
//   board push-buttons in the pixel clock domain. Bit order [0]=C [1]=U
//   [2]=D [3]=R [4]=L. Optional auto-repeat on btn_press is enabled by
//   defining BUTTON_CONDITIONER_AUTOREPEAT_EN.
//
// Ports
//   pixel_clk    in   1      pixel clock (36 MHz)
//   rst          in   1      synchronous reset, active-high
//   btn_raw      in   N_BTN  asynchronous button pins
//   btn_level    out  N_BTN  debounced level, 1 = pressed
//   btn_press    out  N_BTN  1-cycle pulse per press (plus auto-repeats)
//   btn_release  out  N_BTN  1-cycle pulse on debounced release
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int N_BTN           = button_pkg::N_BTN,
    parameter bit RAW_ACTIVE_LOW  = 1'b1,
    parameter int DEBOUNCE_CYCLES = 360_000,
    parameter int REPEAT_DELAY    = 18_000_000,
    parameter int REPEAT_PERIOD   = 3_600_000
) (
    input  logic             pixel_clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    // Polarity normalised before synchronisation: 1 = pressed from here on.
    logic [N_BTN-1:0] btn_norm;
    assign btn_norm = RAW_ACTIVE_LOW ? ~btn_raw : btn_raw;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .pixel_clk   (pixel_clk),
            .rst         (rst),
            .btn_in      (btn_norm[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Self-checking bench for button_conditioner with short debounce/repeat
//   parameters. A behavioural model tracks, per channel, the raw value seen
//   two edges late, how many consecutive edges it has disagreed with the
//   debounced level, and how long the button has been steadily held.
// -----------------------------------------------------------------------------
module tb_button_conditioner;
    import button_pkg::*;

    localparam int DEB  = 8;
    localparam int RDLY = 20;
    localparam int RPER = 5;

    logic             pixel_clk = 1'b0;
    logic             rst       = 1'b1;
    logic [N_BTN-1:0] btn_raw   = '0;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    always #5 pixel_clk = ~pixel_clk;

    button_conditioner #(
        .N_BTN           (N_BTN),
        .RAW_ACTIVE_LOW  (1'b0),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER)
    ) dut (
        .pixel_clk   (pixel_clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge pixel_clk);
            @(negedge pixel_clk);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N_BTN-1:0] m_d1 = '0, m_d2 = '0;
    logic [N_BTN-1:0] m_lvl = '0, m_press = '0, m_rel = '0;
    int               m_run  [N_BTN];
    int               m_hold [N_BTN];
    bit               m_valid = 1'b0;
    bit               s_b, prev_b, steady_b, pulse_b;

    always @(posedge pixel_clk) begin
        if (rst) begin
            m_d1 = '0; m_d2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
            for (int i = 0; i < N_BTN; i++) begin
                m_run[i]  = 0;
                m_hold[i] = 0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                s_b      = m_d2[i];
                prev_b   = m_lvl[i];
                steady_b = (m_run[i] == 0);
                pulse_b  = 1'b0;
                // Level flips on the (DEB+1)-th consecutive disagreeing edge.
                if (s_b != prev_b) begin
                    m_run[i]++;
                    if (m_run[i] == DEB + 1) begin
                        m_lvl[i] = ~prev_b;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                if (prev_b && steady_b && s_b) begin
                    m_hold[i]++;
                    pulse_b = (m_hold[i] == RDLY) ||
                              ((m_hold[i] > RDLY) && ((m_hold[i] - RDLY) % RPER == 0));
                end
`endif
                if (!prev_b && m_lvl[i]) m_hold[i] = 0;
                m_press[i] = (!prev_b && m_lvl[i]) || pulse_b;
                m_rel[i]   = prev_b && !m_lvl[i];
            end
            m_d2 = m_d1;
            m_d1 = btn_raw;
        end
        m_valid = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge pixel_clk) begin
        if (m_valid) begin
            check("model_level",   80'(btn_level),   80'(m_lvl));
            check("model_press",   80'(btn_press),   80'(m_press));
            check("model_release", 80'(btn_release), 80'(m_rel));
        end
    end

    // ---------------- stimulus + literal expectations ----------------
    logic [79:0]      seen, exp_mask;
    logic [N_BTN-1:0] acc, cur;
    int               rem [N_BTN];

    initial begin
        rst = 1'b1;
        step(3);
        check("reset_level", 80'(btn_level), 80'(0));
        check("reset_press", 80'(btn_press | btn_release), 80'(0));
        rst = 1'b0;
        step(3);

        // 1. U pressed and held 40 cycles.
        btn_raw[BTN_U] = 1'b1;
        step(10);
        check("t1_level_e9", 80'(btn_level), 80'(0));
        step(1);
        check("t1_level_e10", 80'(btn_level), 80'(5'b00010));
        check("t1_press_e10", 80'(btn_press), 80'(5'b00010));
        step(1);
        check("t1_press_e11", 80'(btn_press), 80'(0));
        step(28);

        // 3. U released.
        btn_raw[BTN_U] = 1'b0;
        step(10);
        check("t3_level_e9", 80'(btn_level), 80'(5'b00010));
        step(1);
        check("t3_level_e10", 80'(btn_level), 80'(0));
        check("t3_release_e10", 80'(btn_release), 80'(5'b00010));
        check("t3_press_e10", 80'(btn_press), 80'(0));
        step(1);
        check("t3_release_e11", 80'(btn_release), 80'(0));
        step(5);

        // 2. R glitches: 3 high / 2 low, four times.
        acc = '0;
        for (int g = 0; g < 4; g++) begin
            btn_raw[BTN_R] = 1'b1;
            for (int k = 0; k < 3; k++) begin step(1); acc |= btn_level | btn_press | btn_release; end
            btn_raw[BTN_R] = 1'b0;
            for (int k = 0; k < 2; k++) begin step(1); acc |= btn_level | btn_press | btn_release; end
        end
        for (int k = 0; k < 15; k++) begin step(1); acc |= btn_level | btn_press | btn_release; end
        check("t2_glitch_outputs", 80'(acc), 80'(0));

        // 4. C held, reset pulsed mid-count.
        btn_raw[BTN_C] = 1'b1;
        step(8);
        rst = 1'b1;
        step(1);
        check("t4_reset_outputs", 80'(btn_level | btn_press | btn_release), 80'(0));
        rst = 1'b0;
        step(10);
        check("t4_level_before", 80'(btn_level), 80'(0));
        step(1);
        check("t4_level_after", 80'(btn_level), 80'(5'b00001));
        check("t4_press_after", 80'(btn_press), 80'(5'b00001));
        btn_raw[BTN_C] = 1'b0;
        step(15);

        // 5. D held; record edges carrying a press pulse.
        btn_raw[BTN_D] = 1'b1;
        seen = '0;
        for (int k = 0; k < 75; k++) begin
            step(1);
            if (btn_press[BTN_D]) seen[k] = 1'b1;
        end
        exp_mask = '0;
        exp_mask[10] = 1'b1;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        for (int e = 30; e < 75; e += 5) exp_mask[e] = 1'b1;
`endif
        check("t5_press_edges", seen, exp_mask);
        btn_raw[BTN_D] = 1'b0;
        step(15);

        // 6. All buttons on the same edge.
        btn_raw = '1;
        step(11);
        check("t6_level_all", 80'(btn_level), 80'(5'b11111));
        check("t6_press_all", 80'(btn_press), 80'(5'b11111));
        step(1);
        check("t6_press_next", 80'(btn_press), 80'(0));
        btn_raw = '0;
        step(15);

        // Random bounces, holds and occasional resets.
        cur = '0;
        for (int i = 0; i < N_BTN; i++) rem[i] = 0;
        repeat (3000) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (rem[i] == 0) begin
                    cur[i] = ~cur[i];
                    rem[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(9, 60))
                                                         : int'($urandom_range(1, 6));
                end
                rem[i]--;
            end
            btn_raw = cur;
            rst     = ($urandom_range(0, 399) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
